// File: rtl/cpu_boot_pkg.sv
// cpu_boot_pkg: shared state encodings, control-output bundle and counter
// sizing helper for the CPU boot sequencer.
// Contents: ST_* state constants, ctrl_t output bundle, decode_state(), cnt_width().
package cpu_boot_pkg;

  // Sequencer states. Kept as plain localparams so the encoding is stable
  // for anything that probes the state bus directly.
  typedef logic [2:0] boot_state_t;

  localparam boot_state_t ST_IDLE   = 3'd0;
  localparam boot_state_t ST_RESET  = 3'd1;
  localparam boot_state_t ST_LOAD   = 3'd2;
  localparam boot_state_t ST_SETTLE = 3'd3;
  localparam boot_state_t ST_RUN    = 3'd4;
  localparam boot_state_t ST_DONE   = 3'd5;

  // Control outputs that are pure functions of the sequencer state.
  typedef struct packed {
    logic clk_en;
    logic sync_rst;
    logic sys_en;
    logic prog_ready;
    logic running;
    logic done;
  } ctrl_t;

  function automatic ctrl_t decode_state(input boot_state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      ST_RESET: begin
        c.clk_en   = 1'b1;
        c.sync_rst = 1'b1;
      end
      ST_LOAD: begin
        c.clk_en     = 1'b1;
        c.prog_ready = 1'b1;
      end
      ST_SETTLE: begin
        c.clk_en = 1'b1;
      end
      ST_RUN: begin
        c.clk_en  = 1'b1;
        c.sys_en  = 1'b1;
        c.running = 1'b1;
      end
      ST_DONE: begin
        c.done = 1'b1;
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

  // Width of the shared phase counter: enough bits to hold the largest of
  // the three phase lengths. Never narrower than one bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    int w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = $clog2(m + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cpu_boot_sequencer_counter.sv
// boot_down_counter: loadable down counter that stops at zero.
// Ports: clk/rst, i_load + i_load_val (reload), i_en (count), o_zero (count==0).
// The sequencer reloads it on every state entry, so one instance times all phases.
module boot_down_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_en,
  output logic          o_zero
);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/cpu_boot_sequencer.sv
// cpu_boot_sequencer: power-up sequencer in front of CPU_TopLevel. Walks
// IDLE->RESET->LOAD->SETTLE->RUN->DONE, streams the program image into
// instruction memory during LOAD and stops the core on halt or watchdog.
// Ports: clk/rst; i_Start, i_HaltIn; program stream i_ProgValid/i_ProgData/
// i_ProgLast with o_ProgReady; CPU controls o_ClkEnOut/o_SyncRstOut/
// o_SystemEnOut; memory write port o_InstrWrite*; status o_Running/o_Done/
// o_TimeoutFlag/o_OverflowFlag.
module cpu_boot_sequencer
  import cpu_boot_pkg::*;
#(
  parameter int DATABITWIDTH   = 16,
  parameter int IADDRBITWIDTH  = 10,
  parameter int RSTCYCLES      = 2,
  parameter int SETTLECYCLES   = 3,
  parameter int WATCHDOGCYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_Start,
  input  logic                     i_HaltIn,
  input  logic                     i_ProgValid,
  input  logic [DATABITWIDTH-1:0]  i_ProgData,
  input  logic                     i_ProgLast,
  output logic                     o_ProgReady,
  output logic                     o_ClkEnOut,
  output logic                     o_SyncRstOut,
  output logic                     o_SystemEnOut,
  output logic                     o_InstrWriteEn,
  output logic [IADDRBITWIDTH-1:0] o_InstrWriteAddr,
  output logic [DATABITWIDTH-1:0]  o_InstrWriteData,
  output logic                     o_Running,
  output logic                     o_Done,
  output logic                     o_TimeoutFlag,
  output logic                     o_OverflowFlag
);

  localparam int CW    = cnt_width(RSTCYCLES, SETTLECYCLES, WATCHDOGCYCLES);
  localparam bit WD_EN = (WATCHDOGCYCLES > 0);

  // Each phase lasts N cycles, so the counter is loaded with N-1 on entry
  // and the exit transition fires in the cycle it reads zero.
  localparam logic [CW-1:0] RST_LOAD = CW'(RSTCYCLES - 1);
  localparam logic [CW-1:0] SET_LOAD = CW'(SETTLECYCLES - 1);
  localparam logic [CW-1:0] WD_LOAD  = WD_EN ? CW'(WATCHDOGCYCLES - 1) : '0;

  boot_state_t              r_state;
  ctrl_t                    r_ctrl;
  logic [IADDRBITWIDTH-1:0] r_addr;
  logic                     r_ovf;
  logic                     r_to;

  boot_state_t              w_next;
  logic                     w_accept;
  logic                     w_set_ovf;
  logic                     w_set_to;
  logic                     w_cnt_load;
  logic [CW-1:0]            w_cnt_val;
  logic                     w_cnt_en;
  logic                     w_cnt_zero;

  // ProgReady is high exactly in LOAD, so this also gates ProgValid there.
  assign w_accept = r_ctrl.prog_ready && i_ProgValid;

  always_comb begin
    w_next    = r_state;
    w_set_ovf = 1'b0;
    w_set_to  = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_Start) w_next = ST_RESET;
      end
      ST_RESET: begin
        if (w_cnt_zero) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (w_accept) begin
          if (i_ProgLast) begin
            w_next = ST_SETTLE;
          end else if (r_addr == '1) begin
            // Memory full without an end marker: stop loading, flag it.
            w_next    = ST_SETTLE;
            w_set_ovf = 1'b1;
          end
        end
      end
      ST_SETTLE: begin
        if (w_cnt_zero) w_next = ST_RUN;
      end
      ST_RUN: begin
        // Halt has priority over a simultaneous watchdog expiry.
        if (i_HaltIn) begin
          w_next = ST_DONE;
        end else if (WD_EN && w_cnt_zero) begin
          w_next   = ST_DONE;
          w_set_to = 1'b1;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Reload the shared counter on every state change with the length of the
  // phase being entered.
  always_comb begin
    w_cnt_val = '0;
    case (w_next)
      ST_RESET:  w_cnt_val = RST_LOAD;
      ST_SETTLE: w_cnt_val = SET_LOAD;
      ST_RUN:    w_cnt_val = WD_LOAD;
      default:   w_cnt_val = '0;
    endcase
  end

  assign w_cnt_load = (w_next != r_state);
  assign w_cnt_en   = (r_state == ST_RESET) || (r_state == ST_SETTLE) ||
                      (r_state == ST_RUN);

  boot_down_counter #(
    .CW(CW)
  ) u_phase_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_cnt_load),
    .i_load_val(w_cnt_val),
    .i_en      (w_cnt_en),
    .o_zero    (w_cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ctrl  <= '0;
      r_addr  <= '0;
      r_ovf   <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_next;
      // Decode the next state so the control outputs are glitch-free flops
      // that change on the same edge as the state.
      r_ctrl  <= decode_state(w_next);

      if (w_next == ST_RESET) begin
        r_addr <= '0;
      end else if (w_accept) begin
        r_addr <= r_addr + 1'b1;
      end

      // Flags survive DONE and are cleared only when a new sequence starts.
      if (w_next == ST_RESET) begin
        r_ovf <= 1'b0;
        r_to  <= 1'b0;
      end else begin
        if (w_set_ovf) r_ovf <= 1'b1;
        if (w_set_to)  r_to  <= 1'b1;
      end
    end
  end

  assign o_ProgReady      = r_ctrl.prog_ready;
  assign o_ClkEnOut       = r_ctrl.clk_en;
  assign o_SyncRstOut     = r_ctrl.sync_rst;
  assign o_SystemEnOut    = r_ctrl.sys_en;
  assign o_Running        = r_ctrl.running;
  assign o_Done           = r_ctrl.done;
  assign o_TimeoutFlag    = r_to;
  assign o_OverflowFlag   = r_ovf;

  // Write port is combinational so an accepted word lands in the same cycle.
  // Data is zeroed when idle to keep the bus quiet.
  assign o_InstrWriteEn   = w_accept;
  assign o_InstrWriteAddr = r_addr;
  assign o_InstrWriteData = w_accept ? i_ProgData : '0;

endmodule

// File: tb/tb_cpu_boot_sequencer.sv
module tb_cpu_boot_sequencer;

  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int RSTC  = 2;
  localparam int SETC  = 3;
  localparam int WDC   = 16;

  logic          clk;
  logic          rst;
  logic          i_Start;
  logic          i_HaltIn;
  logic          i_ProgValid;
  logic [DW-1:0] i_ProgData;
  logic          i_ProgLast;
  logic          o_ProgReady;
  logic          o_ClkEnOut;
  logic          o_SyncRstOut;
  logic          o_SystemEnOut;
  logic          o_InstrWriteEn;
  logic [AW-1:0] o_InstrWriteAddr;
  logic [DW-1:0] o_InstrWriteData;
  logic          o_Running;
  logic          o_Done;
  logic          o_TimeoutFlag;
  logic          o_OverflowFlag;

  cpu_boot_sequencer #(
    .DATABITWIDTH  (DW),
    .IADDRBITWIDTH (AW),
    .RSTCYCLES     (RSTC),
    .SETTLECYCLES  (SETC),
    .WATCHDOGCYCLES(WDC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_Start         (i_Start),
    .i_HaltIn        (i_HaltIn),
    .i_ProgValid     (i_ProgValid),
    .i_ProgData      (i_ProgData),
    .i_ProgLast      (i_ProgLast),
    .o_ProgReady     (o_ProgReady),
    .o_ClkEnOut      (o_ClkEnOut),
    .o_SyncRstOut    (o_SyncRstOut),
    .o_SystemEnOut   (o_SystemEnOut),
    .o_InstrWriteEn  (o_InstrWriteEn),
    .o_InstrWriteAddr(o_InstrWriteAddr),
    .o_InstrWriteData(o_InstrWriteData),
    .o_Running       (o_Running),
    .o_Done          (o_Done),
    .o_TimeoutFlag   (o_TimeoutFlag),
    .o_OverflowFlag  (o_OverflowFlag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int n_words;      // words offered in the image
    bit has_last;     // ProgLast on the final offered word
    int vmode;        // 0 always valid, 1 every other cycle, 2 random
    int halt_at;      // RUN cycle (1-based) with HaltIn high, 0 = never
    bit start_in_run; // pulse Start on RUN cycle 3
    int exp_writes;
    bit exp_ovf;
    int exp_run;
    bit exp_to;
  } scn_t;

  scn_t tbl[6];
  logic [DW-1:0] img [0:15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: outcome of one sequence from the image shape and
  // halt point, using the load/run rules directly.
  task automatic ref_model(input int n, input bit last, input int halt,
                           output int w, output bit ovf, output int run, output bit to);
    if (last && n <= DEPTH) begin
      w = n; ovf = 1'b0;
    end else begin
      w = DEPTH; ovf = 1'b1;
    end
    if (halt >= 1 && halt <= WDC) begin
      run = halt; to = 1'b0;
    end else begin
      run = WDC; to = 1'b1;
    end
  endtask

  // Drives one complete sequence from IDLE or DONE and checks it cycle by
  // cycle; returns what was observed for comparison against expectations.
  task automatic run_scn(input scn_t s, input bit rnd_data,
                         output int got_w, output bit got_ovf,
                         output int got_run, output bit got_to);
    int  acc;
    int  guard;
    int  cnt;
    int  c;
    bit  v;
    bit  lastw;
    bit  in_load;
    bit  ended;

    for (int i = 0; i < 16; i++)
      img[i] = rnd_data ? DW'($urandom) : DW'(16'h1111 * (i + 1));

    // Start -> RESET for exactly RSTC cycles, flags cleared on entry
    i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
    chk("reset_syncrst_c1", o_SyncRstOut, 1);
    chk("reset_clken", o_ClkEnOut, 1);
    chk("reset_flags", {o_TimeoutFlag, o_OverflowFlag, o_Done}, 0);
    tick();
    chk("reset_syncrst_c2", o_SyncRstOut, 1);
    tick();
    chk("reset_released", o_SyncRstOut, 0);

    // LOAD
    acc = 0; guard = 0; in_load = 1'b1;
    while (in_load && guard < 200) begin
      case (s.vmode)
        0:       v = 1'b1;
        1:       v = (guard % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      lastw       = s.has_last && (acc == s.n_words - 1);
      i_ProgValid = v;
      i_ProgData  = img[acc];
      i_ProgLast  = lastw;
      #1;
      chk("load_ready", o_ProgReady, 1);
      chk("load_write_en", o_InstrWriteEn, v);
      if (v) begin
        chk("load_write_addr", o_InstrWriteAddr, acc % DEPTH);
        chk("load_write_data", o_InstrWriteData, img[acc]);
      end
      tick();
      if (v) begin
        acc++;
        if (lastw || acc == DEPTH) in_load = 1'b0;
      end
      guard++;
    end
    i_ProgValid = 1'b0;
    i_ProgLast  = 1'b0;
    got_w   = acc;

    // First SETTLE cycle: a leftover word must be refused
    if (acc < s.n_words) begin
      i_ProgValid = 1'b1;
      i_ProgData  = img[acc];
      #1;
      chk("extra_word_ready", o_ProgReady, 0);
      chk("extra_word_write_en", o_InstrWriteEn, 0);
      i_ProgValid = 1'b0;
    end
    chk("settle_sysen_low", o_SystemEnOut, 0);
    chk("settle_clken", o_ClkEnOut, 1);

    cnt = 0;
    while (!o_SystemEnOut && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("settle_cycles", cnt, SETC);
    chk("run_running", o_Running, 1);
    got_ovf = o_OverflowFlag;

    // RUN
    c = 1; ended = 1'b0;
    while (!ended && c <= 40) begin
      i_HaltIn = (c == s.halt_at);
      i_Start  = s.start_in_run && (c == 3);
      tick();
      i_HaltIn = 1'b0;
      i_Start  = 1'b0;
      if (o_Done) ended = 1'b1;
      else c++;
    end
    got_run = ended ? c : -1;
    got_to  = o_TimeoutFlag;
    chk("done_outputs", {o_SystemEnOut, o_ClkEnOut, o_Running, o_Done}, 4'b0001);
  endtask

  task automatic compare(input string tag, input int gw, input bit gov, input int gr, input bit gt,
                         input int ew, input bit eov, input int er, input bit et);
    chk({tag, "_writes"}, gw, ew);
    chk({tag, "_overflow"}, gov, eov);
    chk({tag, "_run_cycles"}, gr, er);
    chk({tag, "_timeout"}, gt, et);
    // flags held while sitting in DONE
    tick();
    tick();
    chk({tag, "_done_hold"}, {o_Done, o_TimeoutFlag, o_OverflowFlag}, {1'b1, et, eov});
  endtask

  initial begin
    int gw, gr, ew, er, n, h;
    bit gov, gt, eov, et, lst;
    scn_t rs;

    tbl[0] = '{4, 1'b1, 0, 10, 1'b0, 4, 1'b0, 10, 1'b0};
    tbl[1] = '{5, 1'b1, 1,  0, 1'b0, 5, 1'b0, 16, 1'b1};
    tbl[2] = '{9, 1'b0, 0, 16, 1'b0, 8, 1'b1, 16, 1'b0};
    tbl[3] = '{8, 1'b1, 1,  1, 1'b0, 8, 1'b0,  1, 1'b0};
    tbl[4] = '{3, 1'b1, 0,  0, 1'b1, 3, 1'b0, 16, 1'b1};
    tbl[5] = '{1, 1'b1, 2,  5, 1'b0, 1, 1'b0,  5, 1'b0};

    rst = 1'b1;
    i_Start = 1'b0; i_HaltIn = 1'b0; i_ProgValid = 1'b0;
    i_ProgData = '0; i_ProgLast = 1'b0;
    #12;
    chk("rst_ctrl", {o_ClkEnOut, o_SyncRstOut, o_SystemEnOut, o_ProgReady}, 0);
    chk("rst_status", {o_Running, o_Done, o_TimeoutFlag, o_OverflowFlag}, 0);
    chk("rst_write", {o_InstrWriteEn, o_InstrWriteAddr, o_InstrWriteData}, 0);
    @(negedge clk);
    rst = 1'b0;

    // IDLE holds with no Start; HaltIn and ProgValid ignored
    i_HaltIn = 1'b1; i_ProgValid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("idle_hold", {o_ClkEnOut, o_SyncRstOut, o_Done, o_InstrWriteEn}, 0);
    end
    i_HaltIn = 1'b0; i_ProgValid = 1'b0;

    // rst mid-LOAD after two words
    i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      i_ProgValid = 1'b1; i_ProgData = DW'(16'hA000 + k);
      tick();
    end
    i_ProgData = 16'hA002;
    #1;
    chk("midload_write_en", o_InstrWriteEn, 1);
    chk("midload_addr", o_InstrWriteAddr, 2);
    rst = 1'b1;
    #1;
    chk("midload_rst_ctrl", {o_ClkEnOut, o_SyncRstOut, o_SystemEnOut, o_ProgReady}, 0);
    chk("midload_rst_write", {o_InstrWriteEn, o_InstrWriteAddr, o_InstrWriteData}, 0);
    @(negedge clk);
    rst = 1'b0;
    i_ProgValid = 1'b0;
    tick();

    // table-driven sequences, chained through DONE
    for (int i = 0; i < 6; i++) begin
      run_scn(tbl[i], 1'b0, gw, gov, gr, gt);
      compare($sformatf("tbl%0d", i), gw, gov, gr, gt,
              tbl[i].exp_writes, tbl[i].exp_ovf, tbl[i].exp_run, tbl[i].exp_to);
    end

    // randomized sequences against the reference model
    for (int i = 0; i < 15; i++) begin
      n   = $urandom_range(1, 10);
      lst = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      h   = $urandom_range(0, 20);
      rs  = '{n, lst, 2, h, 1'b0, 0, 1'b0, 0, 1'b0};
      ref_model(n, lst, h, ew, eov, er, et);
      run_scn(rs, 1'b1, gw, gov, gr, gt);
      compare($sformatf("rnd%0d", i), gw, gov, gr, gt, ew, eov, er, et);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=expired required=finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/cpu_boot_sequencer.md
# cpu_boot_sequencer

Drives the CPU_TopLevel control inputs (clock enable, synchronous reset, system enable) through a fixed power-up sequence. Also streams a program image into instruction memory before release, and stops the core on halt or watchdog expiry. It sits directly upstream of CPU_TopLevel and replaces hand-built count comparisons used to sequence the core.

## Interface
- DATABITWIDTH, 16, instruction/program word width
- IADDRBITWIDTH, 10, instruction memory address width
- RSTCYCLES, 2, cycles SyncRstOut is held (≥1)
- SETTLECYCLES, 3, cycles between load end and SystemEn (≥1)
- WATCHDOGCYCLES, 1024, max RUN cycles before forced stop; 0 disables watchdog
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- Start  in  1  begin sequence (sampled in IDLE/DONE only)
- HaltIn  in  1  core halt indication
- ProgValid  in  1  program word valid
- ProgData  in  DATABITWIDTH  program word
- ProgLast  in  1  final word of image, qualified by ProgValid
- ProgReady  out  1  block accepts program words
- ClkEnOut  out  1  to CPU clk_en
- SyncRstOut  out  1  to CPU sync_rst
- SystemEnOut  out  1  to CPU SystemEn
- InstrWriteEn  out  1  instruction memory write strobe
- InstrWriteAddr  out  IADDRBITWIDTH  write address
- InstrWriteData  out  DATABITWIDTH  write data
- Running  out  1  state is RUN
- Done  out  1  state is DONE
- TimeoutFlag  out  1  last run ended by watchdog
- OverflowFlag  out  1  last load filled memory without ProgLast

## Operation
- States: IDLE → RESET → LOAD → SETTLE → RUN → DONE; DONE → RESET on Start.
- IDLE: all outputs 0. Start=1 → RESET; flags cleared.
- RESET: ClkEnOut=1, SyncRstOut=1 for exactly RSTCYCLES cycles, then LOAD; address counter cleared.
- LOAD: ClkEnOut=1, ProgReady=1. Word accepted when ProgValid&&ProgReady: InstrWriteEn=1, write data/address presented same cycle (combinational from inputs/address reg), address increments. Accepted word with ProgLast → SETTLE. Accepted word at address 2^IADDRBITWIDTH−1 without ProgLast → SETTLE, OverflowFlag=1; address wraps to 0 but no further writes.
- SETTLE: ClkEnOut=1, SystemEnOut=0 for SETTLECYCLES cycles, then RUN.
- RUN: ClkEnOut=1, SystemEnOut=1, Running=1; watchdog counts RUN cycles. HaltIn=1 → DONE. Watchdog reaching WATCHDOGCYCLES → DONE, TimeoutFlag=1. HaltIn and expiry same cycle: halt wins, TimeoutFlag=0.
- DONE: ClkEnOut=0, SystemEnOut=0, Done=1; flags held until next Start.
- HaltIn ignored outside RUN; Start ignored in RESET/LOAD/SETTLE/RUN; ProgValid ignored outside LOAD.
- rst at any time: immediate return to IDLE, all registers and outputs 0, partial load abandoned.

## Timing
- All outputs except InstrWriteEn/Addr/Data are registered decodes of state; reset value of every output is 0.
- Start sampled at edge n → RESET visible after edge n (SyncRstOut=1 cycles n+1..n+RSTCYCLES).
- LOAD throughput one word per cycle; ProgReady drops the cycle after the ProgLast/overflow word.
- SystemEnOut rises exactly SETTLECYCLES cycles after leaving LOAD.
- HaltIn at edge m → Done=1, SystemEnOut=0 after edge m (1-cycle latency).
- Watchdog: expiry after exactly WATCHDOGCYCLES cycles with SystemEnOut=1.

## Structure
- Package cpu_boot_pkg: state enum (IDLE, RESET, LOAD, SETTLE, RUN, DONE), counter width = $clog2(max(RSTCYCLES, SETTLECYCLES, WATCHDOGCYCLES)+1).
- One sub-module: boot_down_counter (load value, enable, zero flag), shared for RESET, SETTLE and watchdog phases, reloaded on each state entry.

## Test plan
- Start with 4-word image (0x1111..0x4444, ProgLast on 4th) → writes at addr 0..3, SyncRstOut high 2 cycles, SystemEnOut rises 3 cycles after last write.
- ProgValid toggling every other cycle → only accepted words written, addresses contiguous, no duplicate writes.
- IADDRBITWIDTH=3, 8 words no ProgLast → OverflowFlag=1, 9th word not accepted (ProgReady=0), RUN reached.
- HaltIn pulsed 10 cycles into RUN → Done=1 next cycle, TimeoutFlag=0; WATCHDOGCYCLES=16 no halt → DONE after 16 RUN cycles, TimeoutFlag=1; halt on 16th cycle → TimeoutFlag=0.
- rst asserted mid-LOAD after 2 words → all outputs 0 immediately; fresh Start reloads from addr 0.
- Start in DONE → full sequence repeats, flags cleared on entry to RESET; Start pulses during RUN have no effect.
